// File: rtl/ccl_window_gen_pkg.sv
// Shared types and defaults for the connected-components window generator.
package ccl_window_gen_pkg;

  // Default label and coordinate widths shared with the labeller.
  localparam int unsigned WordSize = 8;
  localparam int unsigned LocSize  = 10;

  // Issue/wait/capture sequencing: one pixel in flight at a time.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReady   = 2'd1,
    StWait    = 2'd2,
    StCapture = 2'd3
  } win_state_e;

endpackage

// File: rtl/ccl_window_gen_label_line_buf.sv
// One-row label store: two asynchronous reads, one synchronous write.
// Contents are not reset; the top masks row 0 so stale labels never escape.
module ccl_window_gen_label_line_buf #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  output logic [Width-1:0] rdata_a_o,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] mem_q [Depth];

  // Synchronous write; reads below see the old word during the write cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/ccl_window_gen.sv
// Raster scanner feeding the connected-components labeller. Issues one pixel
// every LAT+1 cycles with its causal neighbourhood (A,B,C from the previous
// row, D from the current row), then captures the returned label into the
// line buffer so it becomes the neighbourhood of later pixels.
module ccl_window_gen
  import ccl_window_gen_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned WORD_SIZE  = WordSize,
  parameter int unsigned LOC_SIZE   = LocSize,
  parameter int unsigned LAT        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 pix,
  output logic                 win_valid,
  output logic [WORD_SIZE-1:0] A,
  output logic [WORD_SIZE-1:0] B,
  output logic [WORD_SIZE-1:0] C,
  output logic [WORD_SIZE-1:0] D,
  output logic                 p,
  output logic [LOC_SIZE-1:0]  x,
  output logic [LOC_SIZE-1:0]  y,
  input  logic [WORD_SIZE-1:0] q,
  output logic                 frame_done
);

  localparam int unsigned AddrW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned CntW  = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CntW-1:0]     WaitLoad = CntW'(LAT - 1);
  localparam logic [LOC_SIZE-1:0] LastX    = LOC_SIZE'(IMG_WIDTH - 1);
  localparam logic [LOC_SIZE-1:0] LastY    = LOC_SIZE'(IMG_HEIGHT - 1);

  win_state_e           state_q, state_d;
  logic [CntW-1:0]      wait_q, wait_d;
  logic [LOC_SIZE-1:0]  x_q, x_d;
  logic [LOC_SIZE-1:0]  y_q, y_d;
  logic [WORD_SIZE-1:0] a_q, a_d;
  logic [WORD_SIZE-1:0] d_q, d_d;
  logic                 frame_done_q, frame_done_d;

  logic                 issue;
  logic                 last_col;
  logic                 last_row;
  logic                 lb_we;
  logic [AddrW-1:0]     raddr_b;
  logic [AddrW-1:0]     raddr_c;
  logic [WORD_SIZE-1:0] b_raw;
  logic [WORD_SIZE-1:0] c_raw;

  assign issue    = (state_q == StReady) && pix_valid;
  assign last_col = (x_q == LastX);
  assign last_row = (y_q == LastY);

  // C is clamped at the right edge so the buffer is never read past its end;
  // the value is masked anyway.
  assign raddr_b = x_q[AddrW-1:0];
  assign raddr_c = last_col ? x_q[AddrW-1:0] : x_q[AddrW-1:0] + 1'b1;

  ccl_window_gen_label_line_buf #(
    .Depth (IMG_WIDTH),
    .Width (WORD_SIZE),
    .AddrW (AddrW)
  ) u_line_buf (
    .clk_i     (clk),
    .we_i      (lb_we),
    .waddr_i   (x_q[AddrW-1:0]),
    .wdata_i   (q),
    .raddr_a_i (raddr_b),
    .rdata_a_o (b_raw),
    .raddr_b_i (raddr_c),
    .rdata_b_o (c_raw)
  );

  // Next-state: sequencing, wait countdown, label capture and scan advance.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    x_d          = x_q;
    y_d          = y_q;
    a_d          = a_q;
    d_d          = d_q;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StReady;
      end
      StReady: begin
        if (pix_valid) begin
          wait_d  = WaitLoad;
          // With LAT of 1 the capture cycle immediately follows issue.
          state_d = (LAT == 1) ? StCapture : StWait;
        end
      end
      StWait: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == CntW'(1)) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        lb_we = 1'b1;
        // Old linebuf[x] is this pixel's B, i.e. the next pixel's A.
        a_d   = b_raw;
        d_d   = q;
        if (last_col) begin
          x_d = '0;
          if (last_row) begin
            y_d          = '0;
            frame_done_d = 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
        state_d = StReady;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and scan registers; reset abandons any pixel in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      a_q          <= '0;
      d_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      x_q          <= x_d;
      y_q          <= y_d;
      a_q          <= a_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window outputs: real neighbourhood on the issue cycle, background otherwise.
  always_comb begin
    pix_ready = (state_q == StReady);
    win_valid = issue;
    p         = 1'b0;
    A         = '0;
    B         = '0;
    C         = '0;
    D         = '0;
    if (issue) begin
      p = pix;
      if (y_q != '0) begin
        B = b_raw;
        if (!last_col) begin
          C = c_raw;
        end
        if (x_q != '0) begin
          A = a_q;
        end
      end
      if (x_q != '0) begin
        D = d_q;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ccl_window_gen.sv
// Scoreboard bench for ccl_window_gen on a 4x2 image with LAT=2. The stimulus
// thread pushes the expected window for every pixel it offers; the monitor
// thread pops on each win_valid, doubles as the labeller stub driving q only
// in the exact capture cycle, and tracks frame_done and issue spacing.
module tb_ccl_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned L  = 2;
  localparam int unsigned WS = 8;
  localparam int unsigned LS = 10;

  typedef struct {
    int          x;
    int          y;
    logic        p;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  lbl;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix = 1'b0;
  logic          pix_ready, win_valid, p, frame_done;
  logic [WS-1:0] a_o, b_o, c_o, d_o, q;
  logic [LS-1:0] x_o, y_o;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   gap_count = 0;
  bit   stim_done = 1'b0;
  bit   q_armed = 1'b0;
  int   q_cyc = 0;
  logic [7:0] q_label = 8'd0;
  int   fd_cyc = -100;
  int   last_issue = -100;
  int   gap_seen = 0;
  int   fd_pulses = 0;
  int   sx = 0;
  int   sy = 0;
  int   mode = 0;
  int   waited;

  ccl_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .WORD_SIZE  (WS),
    .LOC_SIZE   (LS),
    .LAT        (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix        (pix),
    .win_valid  (win_valid),
    .A          (a_o),
    .B          (b_o),
    .C          (c_o),
    .D          (d_o),
    .p          (p),
    .x          (x_o),
    .y          (y_o),
    .q          (q),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Labeller stub: the label is visible only LAT cycles after its issue cycle.
  assign q = (q_armed && (cyc == q_cyc + int'(L))) ? q_label : 8'hEE;

  function automatic logic [7:0] lab(input int m, input int xx, input int yy);
    if (m == 0) return 8'd7;
    if (m == 1) return (yy == 0) ? 8'(xx + 1) : 8'(10 + xx);
    return 8'(20 + xx + 4 * yy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_expected(input logic px);
    exp_t e;
    e.x   = sx;
    e.y   = sy;
    e.p   = px;
    e.lbl = lab(mode, sx, sy);
    e.b   = (sy > 0) ? lab(mode, sx, sy - 1) : 8'd0;
    e.c   = (sy > 0 && sx < int'(W) - 1) ? lab(mode, sx + 1, sy - 1) : 8'd0;
    e.a   = (sy > 0 && sx > 0) ? lab(mode, sx - 1, sy - 1) : 8'd0;
    e.d   = (sx > 0) ? lab(mode, sx - 1, sy) : 8'd0;
    exp_q.push_back(e);
    if (sx == int'(W) - 1) begin
      sx = 0;
      if (sy == int'(H) - 1) begin
        sy = 0;
        mode++;
      end else begin
        sy++;
      end
    end else begin
      sx++;
    end
  endtask

  // Offer one pixel and return just after the accepting edge.
  task automatic send(input logic px, input bit toggle, output int nwait);
    push_expected(px);
    pix_valid = 1'b1;
    pix       = px;
    nwait     = 0;
    while (1) begin
      @(negedge clk);
      if (pix_ready) break;
      nwait++;
      if (nwait > 50) begin
        check("accept_timeout", 64'(nwait), 64'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    if (toggle) begin
      pix_valid = 1'b0;
      pix       = ~px;
      #3 pix_valid = 1'b1;
      @(posedge clk);
      #1 pix_valid = 1'b0;
      #3 pix_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    fork
      // Stimulus thread
      begin
        @(negedge clk);
        check("reset_state", 64'({pix_ready, win_valid, p, a_o, b_o, c_o, d_o, x_o, y_o,
                                  frame_done}), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Frame 0, all labels 7: stall after (2,0), toggling pix_valid in WAIT.
        for (int i = 0; i < int'(W * H); i++) begin
          send(1'b1, (i == 4 || i == 5), waited);
          if (i == 2) begin
            pix_valid = 1'b0;
            repeat (L) @(posedge clk);
            #1;
            gap_count++;
            for (int k = 0; k < 10; k++) begin
              @(negedge clk);
              check("stall_hold", 64'({pix_ready, win_valid, x_o, y_o}),
                    64'({1'b1, 1'b0, LS'(sx), LS'(sy)}));
            end
            @(posedge clk);
            #1;
            send(1'b0, 1'b0, waited);
            check("stall_resume_wait", 64'(waited), 64'(0));
            i++;
          end
        end

        // Frame 1: row 0 labels x+1, row 1 labels 10+x; starts over stale buffer.
        for (int i = 0; i < int'(W * H); i++) begin
          send(logic'(i % 3 == 0), 1'b0, waited);
        end

        // Frame 2: abandon it in WAIT of pixel (2,1).
        for (int i = 0; i < int'(W) + 3; i++) begin
          send(1'b1, 1'b0, waited);
        end
        #1 reset = 1'b1;
        pix_valid = 1'b0;
        #1;
        check("async_reset", 64'({pix_ready, win_valid, p, a_o, b_o, c_o, d_o, x_o, y_o,
                                  frame_done}), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sx   = 0;
        sy   = 0;
        mode = 2;

        // Frame 3: full frame after the mid-frame reset.
        for (int i = 0; i < int'(W * H); i++) begin
          send(logic'(i[0]), 1'b0, waited);
        end
        pix_valid = 1'b0;
        repeat (8) @(posedge clk);
        check("frame_done_count", 64'(fd_pulses), 64'(3));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        stim_done = 1'b1;
      end

      // Monitor and labeller stub thread
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (reset) begin
            q_armed    = 1'b0;
            fd_cyc     = -100;
            last_issue = -100;
            continue;
          end
          if (frame_done || cyc == fd_cyc) begin
            check("frame_done", 64'(frame_done), 64'(cyc == fd_cyc));
          end
          if (frame_done) fd_pulses++;
          if (win_valid) begin
            if (exp_q.size() == 0) begin
              check("spurious_issue", 64'(1), 64'(0));
            end else begin
              mon_e = exp_q.pop_front();
              check("window", 64'({x_o, y_o, p, a_o, b_o, c_o, d_o}),
                    64'({LS'(mon_e.x), LS'(mon_e.y), mon_e.p, mon_e.a, mon_e.b, mon_e.c,
                         mon_e.d}));
              if (last_issue >= 0 && gap_seen == gap_count) begin
                check("issue_interval", 64'(cyc - last_issue), 64'(L + 1));
              end
              gap_seen   = gap_count;
              last_issue = cyc;
              q_label    = mon_e.lbl;
              q_cyc      = cyc;
              q_armed    = 1'b1;
              if (mon_e.x == int'(W) - 1 && mon_e.y == int'(H) - 1) begin
                fd_cyc = cyc + int'(L) + 1;
              end
            end
          end else begin
            check("bubble", 64'({p, a_o, b_o, c_o, d_o}), 64'(0));
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
